// File: rtl/cam_priority_encoder.sv
//==============================================================================
// Module      : cam_priority_encoder
// Description : Walks the set bits of a CAM match-line vector lowest-first and
//               emits one entry address per ready/valid beat.
//               Optional macro CAM_ENC_FLUSH_EN adds flush_i to abort a drain.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cam_priority_encoder #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = (1 << ADDR_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  match_valid_i,
    output logic                  match_ready_o,
    input  logic [DEPTH-1:0]      match_i,
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o,
    output logic                  miss_o,
    output logic [ADDR_WIDTH:0]   match_count_o
`ifdef CAM_ENC_FLUSH_EN
    ,
    input  logic                  flush_i
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam logic [DEPTH-1:0] c_ONE = DEPTH'(1);

    state_e                r_state_q,   w_state_d;
    logic [DEPTH-1:0]      r_pending_q, w_pending_d;
    logic [ADDR_WIDTH:0]   r_count_q,   w_count_d;
    logic                  r_miss_q,    w_miss_d;

    logic [DEPTH-1:0]      w_pending_clr;
    logic [ADDR_WIDTH-1:0] w_low_idx;
    logic [ADDR_WIDTH:0]   w_popcount;
    logic                  w_last;
    logic                  w_flush;

`ifdef CAM_ENC_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    // Clearing the lowest set bit; pending becoming empty marks the final beat.
    assign w_pending_clr = r_pending_q & (r_pending_q - c_ONE);
    assign w_last        = (r_pending_q != '0) && (w_pending_clr == '0);

    // Downward scan so the lowest set bit is the one that sticks.
    always_comb begin
        w_low_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (r_pending_q[k]) begin
                w_low_idx = ADDR_WIDTH'(k);
            end
        end
    end

    always_comb begin
        w_popcount = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_popcount = w_popcount + (ADDR_WIDTH + 1)'(match_i[k]);
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_pending_d = r_pending_q;
        w_count_d   = r_count_q;
        w_miss_d    = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (match_valid_i) begin
                    w_count_d = w_popcount;
                    if (match_i == '0) begin
                        w_miss_d = 1'b1;
                    end else begin
                        w_pending_d = match_i;
                        w_state_d   = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (w_flush) begin
                    w_pending_d = '0;
                    w_state_d   = ST_IDLE;
                end else if (addr_ready_i) begin
                    w_pending_d = w_pending_clr;
                    if (w_last) begin
                        w_state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                w_pending_d = '0;
                w_state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state_q   <= ST_IDLE;
            r_pending_q <= '0;
            r_count_q   <= '0;
            r_miss_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_pending_q <= w_pending_d;
            r_count_q   <= w_count_d;
            r_miss_q    <= w_miss_d;
        end
    end

    assign match_ready_o = (r_state_q == ST_IDLE);
    assign addr_valid_o  = (r_state_q == ST_EMIT);
    assign addr_o        = w_low_idx;
    assign last_o        = w_last;
    assign miss_o        = r_miss_q;
    assign match_count_o = r_count_q;

endmodule

`default_nettype wire
